// File: rtl/mdu_divider_pkg.sv
// Shared constants for the iterative MIPS DIV/DIVU unit: width, FSM encodings, counter sizing.
package mdu_divider_pkg;

  localparam int DIV_DATA_W = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int DIV_CNT_W = cnt_width(DIV_DATA_W);

endpackage

// File: rtl/mdu_divider_step.sv
// One restoring-division iteration: (DATA_W+1)-bit trial subtract, sign selects restore.
module mdu_divider_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic              bit_i,
  input  logic [DATA_W-1:0] dvs_i,
  output logic [DATA_W-1:0] rem_o,
  output logic              q_bit_o
);

  logic [DATA_W:0] partial;
  logic [DATA_W:0] diff;

  // rem < divisor holds between steps, so a non-negative difference always fits DATA_W bits
  assign partial = {rem_i, bit_i};
  assign diff    = partial - {1'b0, dvs_i};
  assign q_bit_o = ~diff[DATA_W];
  assign rem_o   = diff[DATA_W] ? partial[DATA_W-1:0] : diff[DATA_W-1:0];

endmodule

// File: rtl/mdu_divider.sv
// Iterative restoring divider for MIPS DIV/DIVU: quotient to LO, remainder to HI.
// Magnitudes are divided unsigned for DATA_W cycles, then a FIX cycle applies signs.
module mdu_divider
  import mdu_divider_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_signed,
  input  logic              cancel,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              div_by_zero
);

  localparam int CNT_W = cnt_width(DATA_W);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic              zero_q, zero_d;
  logic [DATA_W-1:0] quo_out_q, quo_out_d;
  logic [DATA_W-1:0] rem_out_q, rem_out_d;
  logic              dbz_q, dbz_d;

  logic [DATA_W-1:0] dvd_mag, dvs_mag;
  logic [DATA_W-1:0] step_rem;
  logic              step_bit;

  // Unary minus at DATA_W width keeps |-2^(DATA_W-1)| exact as an unsigned value
  assign dvd_mag = (is_signed && dividend[DATA_W-1]) ? -dividend : dividend;
  assign dvs_mag = (is_signed && divisor[DATA_W-1])  ? -divisor  : divisor;

  mdu_divider_step #(.DATA_W(DATA_W)) u_step (
    .rem_i   (rem_q),
    .bit_i   (quo_q[DATA_W-1]),
    .dvs_i   (dvs_q),
    .rem_o   (step_rem),
    .q_bit_o (step_bit)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    zero_d    = zero_q;
    quo_out_d = quo_out_q;
    rem_out_d = rem_out_q;
    dbz_d     = dbz_q;

    if (cancel) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          state_d = ST_IDLE;
          if (start) begin
            state_d = ST_CALC;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = dvd_mag;
            dvs_d   = dvs_mag;
            qneg_d  = is_signed & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
            rneg_d  = is_signed & dividend[DATA_W-1];
            zero_d  = (divisor == '0);
          end
        end
        ST_CALC: begin
          rem_d = step_rem;
          quo_d = {quo_q[DATA_W-2:0], step_bit};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) state_d = ST_FIX;
        end
        ST_FIX: begin
          // A zero divisor leaves the dividend magnitude in rem; re-signing restores the original
          quo_out_d = zero_q ? '1 : (qneg_q ? -quo_q : quo_q);
          rem_out_d = rneg_q ? -rem_q : rem_q;
          dbz_d     = zero_q;
          state_d   = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      zero_q    <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      zero_q    <= zero_d;
      quo_out_q <= quo_out_d;
      rem_out_q <= rem_out_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign done        = (state_q == ST_DONE);
  assign quotient    = quo_out_q;
  assign remainder   = rem_out_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mdu_divider.sv
// Directed bench for mdu_divider with a result scoreboard popped on each done pulse.
module tb_mdu_divider;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic        cancel = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  res_t exp_q[$];
  res_t last;
  int   vectors = 0;
  int   fails = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  mdu_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .cancel      (cancel),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      res_t e;
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("done_without_op", {31'b0, done}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.z});
      end
    end
  end

  // Issues an op in the current cycle and returns in its DONE cycle.
  task automatic run_op(input bit sg, input logic [31:0] a, input logic [31:0] b,
                        input res_t e, input bit glitch);
    int lat;
    bit busy_ok;
    is_signed = sg;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    exp_q.push_back(e);
    last = e;
    tick();
    start   = 1'b0;
    lat     = 1;
    busy_ok = 1'b1;
    while (!done && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      if (glitch && (lat == 5 || lat == 20)) begin
        start    = 1'b1;
        dividend = 32'd1;
        divisor  = 32'd1;
      end
      tick();
      start = 1'b0;
      lat++;
    end
    check("latency", lat, 32'd34);
    check("busy_span", {31'b0, busy_ok}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    #12;
    check("reset_flags", {29'b0, busy, done, div_by_zero}, 32'd0);
    check("reset_quotient", quotient, 32'd0);
    check("reset_remainder", remainder, 32'd0);
    rst_n = 1'b1;
    tick();

    run_op(1'b0, 32'd100, 32'd7, res_t'{32'd14, 32'd2, 1'b0}, 1'b0); tick();
    run_op(1'b1, 32'hFFFFFFF9, 32'd2, res_t'{32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0}, 1'b0); tick();
    run_op(1'b1, 32'd7, 32'hFFFFFFFE, res_t'{32'hFFFFFFFD, 32'd1, 1'b0}, 1'b0); tick();
    run_op(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, res_t'{32'd3, 32'hFFFFFFFF, 1'b0}, 1'b0); tick();
    run_op(1'b0, 32'hFFFFFFF9, 32'd2, res_t'{32'h7FFFFFFC, 32'd1, 1'b0}, 1'b0); tick();
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, res_t'{32'h80000000, 32'd0, 1'b0}, 1'b0); tick();
    run_op(1'b0, 32'd5, 32'd0, res_t'{32'hFFFFFFFF, 32'd5, 1'b1}, 1'b0); tick();
    run_op(1'b1, 32'hFFFFFFF6, 32'd0, res_t'{32'hFFFFFFFF, 32'hFFFFFFF6, 1'b1}, 1'b0); tick();

    // start pulses while busy must not launch or queue anything
    d0 = done_cnt;
    run_op(1'b0, 32'd1000, 32'd10, res_t'{32'd100, 32'd0, 1'b0}, 1'b1);
    repeat (5) tick();
    check("glitch_done_count", done_cnt - d0, 32'd1);

    // second start lands in the DONE cycle of the first
    run_op(1'b0, 32'd50, 32'd7, res_t'{32'd7, 32'd1, 1'b0}, 1'b0);
    run_op(1'b1, 32'hFFFFFFEC, 32'd3, res_t'{32'hFFFFFFFA, 32'hFFFFFFFE, 1'b0}, 1'b0);
    tick();
    check("done_one_cycle", {31'b0, done}, 32'd0);

    // cancel with a simultaneous start in cycle 10 of an op
    is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    cancel = 1'b1; start = 1'b1; dividend = 32'd77; divisor = 32'd5;
    tick();
    cancel = 1'b0; start = 1'b0;
    check("cancel_busy", {31'b0, busy}, 32'd0);
    d0 = done_cnt;
    repeat (40) tick();
    check("cancel_no_done", done_cnt, d0);
    check("cancel_keep_q", quotient, last.q);
    check("cancel_keep_r", remainder, last.r);
    check("cancel_keep_z", {31'b0, div_by_zero}, {31'b0, last.z});
    run_op(1'b0, 32'd9, 32'd3, res_t'{32'd3, 32'd0, 1'b0}, 1'b0); tick();

    // asynchronous reset mid-CALC
    is_signed = 1'b0; dividend = 32'h0000FFFF; divisor = 32'd3; start = 1'b1;
    exp_q.push_back(res_t'{32'h00005555, 32'd0, 1'b0});
    tick();
    start = 1'b0;
    repeat (10) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_flags", {29'b0, busy, done, div_by_zero}, 32'd0);
    check("arst_quotient", quotient, 32'd0);
    check("arst_remainder", remainder, 32'd0);
    exp_q.delete();
    #3;
    rst_n = 1'b1;
    tick();
    run_op(1'b0, 32'hFFFFFFFF, 32'h10, res_t'{32'h0FFFFFFF, 32'hF, 1'b0}, 1'b0);
    tick();
    tick();

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
